// File: rtl/cycle_limit_timer_pkg.sv
// Shared definitions for the cycle limit timer: state encoding, mode
// constants, wrap counter width and a saturating increment helper.
package cycle_limit_timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int WRAPS_W = 8;

  // Increment that sticks at all-ones instead of rolling over.
  function automatic logic [WRAPS_W-1:0] sat_inc(input logic [WRAPS_W-1:0] v);
    return (v == {WRAPS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cycle_limit_timer_prescaler.sv
// Tick generator: one tick every PRESCALE enabled cycles. The phase counter
// advances only while enable is high, so a paused timer keeps its phase.
// PRESCALE=1 degenerates to a wire (tick == enable).
module clt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, restart};
      assign tick = enable;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] pcnt;

      assign tick = enable && (pcnt == PW'(PRESCALE - 1));

      // Phase counter: reset/restart to zero, wrap on each tick.
      always_ff @(posedge clk) begin
        if (rst || restart)
          pcnt <= '0;
        else if (enable)
          pcnt <= tick ? '0 : pcnt + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/cycle_limit_timer.sv
// Cycle limit timer: counts prescaled ticks from 0 up to a latched limit,
// then either stops (one-shot, sets done) or reloads (periodic, bumps wraps).
// Optional input capture is enabled by defining CYCLE_LIMIT_TIMER_CAPTURE_EN.
module cycle_limit_timer
  import cycle_limit_timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  input  logic               clear,
  input  logic [WIDTH-1:0]   limit,
  input  logic               periodic,
  output logic [WIDTH-1:0]   count,
  output logic               expire,
  output logic               done,
  output logic               busy,
  output logic [WRAPS_W-1:0] wraps
`ifdef CYCLE_LIMIT_TIMER_CAPTURE_EN
  ,
  input  logic               capture,
  output logic [WIDTH-1:0]   cap_count
`endif
);

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;
  logic             tick;
  logic             at_lim;

  assign at_lim = (count == lim_q);

  // start and clear both realign the prescaler phase to zero.
  clt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (clear | start),
    .enable  (state == ST_RUN),
    .tick    (tick)
  );

  // Next-state selection; clear beats start beats hold.
  always_comb begin
    state_nx = state;
    if (clear)
      state_nx = ST_IDLE;
    else if (start)
      state_nx = ST_RUN;
    else begin
      case (state)
        ST_RUN: begin
          if (tick && at_lim && (mode_q == MODE_ONESHOT))
            state_nx = ST_DONE;
          else if (hold)
            state_nx = ST_PAUSE;
        end
        ST_PAUSE: if (!hold) state_nx = ST_RUN;
        default:  state_nx = state;
      endcase
    end
  end

  // State register and registered busy flag derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
    end
  end

  // Count, expire pulse, done flag, wrap counter and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      expire <= 1'b0;
      done   <= 1'b0;
      wraps  <= '0;
      lim_q  <= '0;
      mode_q <= MODE_ONESHOT;
    end else begin
      expire <= 1'b0;
      if (clear) begin
        count <= '0;
        done  <= 1'b0;
        wraps <= '0;
      end else if (start) begin
        count  <= '0;
        done   <= 1'b0;
        wraps  <= '0;
        lim_q  <= limit;
        mode_q <= periodic;
      end else if ((state == ST_RUN) && tick) begin
        if (at_lim) begin
          expire <= 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            count <= '0;
            wraps <= sat_inc(wraps);
          end else begin
            done <= 1'b1;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

`ifdef CYCLE_LIMIT_TIMER_CAPTURE_EN
  // Snapshot of count on capture; zeroed by reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cap_count <= '0;
    else if (capture)
      cap_count <= count;
  end
`endif

endmodule

// File: tb/tb_cycle_limit_timer.sv
// Bench for cycle_limit_timer: two instances (PRESCALE=1 and PRESCALE=4)
// share inputs; each is compared every cycle against a behavioural model,
// plus directed checks of the documented scenarios.
module tb_cycle_limit_timer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, hold, clear, periodic, capture;
  logic [W-1:0] limit;

  logic [W-1:0] cnt_o  [2];
  logic         exp_o  [2];
  logic         done_o [2];
  logic         busy_o [2];
  logic [7:0]   wr_o   [2];
  logic [W-1:0] cap_o  [2];

  cycle_limit_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .clear(clear),
    .limit(limit), .periodic(periodic), .count(cnt_o[0]), .expire(exp_o[0]),
    .done(done_o[0]), .busy(busy_o[0]), .wraps(wr_o[0])
`ifdef CYCLE_LIMIT_TIMER_CAPTURE_EN
    , .capture(capture), .cap_count(cap_o[0])
`endif
  );

  cycle_limit_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .clear(clear),
    .limit(limit), .periodic(periodic), .count(cnt_o[1]), .expire(exp_o[1]),
    .done(done_o[1]), .busy(busy_o[1]), .wraps(wr_o[1])
`ifdef CYCLE_LIMIT_TIMER_CAPTURE_EN
    , .capture(capture), .cap_count(cap_o[1])
`endif
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Behavioural model: phase 0=stopped,1=counting,2=paused,3=finished.
  int PS [2] = '{1, 4};
  int m_ph [2], m_cnt [2], m_pc [2], m_lim [2], m_wr [2], m_cap [2];
  bit m_per [2], m_exp [2], m_dn [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int old;
      old = m_cnt[i];
      m_exp[i] = 0;
      if (rst) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_pc[i] = 0; m_lim[i] = 0;
        m_per[i] = 0; m_wr[i] = 0; m_dn[i] = 0;
      end else if (clear) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_pc[i] = 0; m_wr[i] = 0; m_dn[i] = 0;
      end else if (start) begin
        m_ph[i] = 1; m_cnt[i] = 0; m_pc[i] = 0; m_wr[i] = 0; m_dn[i] = 0;
        m_lim[i] = int'(limit); m_per[i] = periodic;
      end else if (m_ph[i] == 1) begin
        m_pc[i]++;
        if (m_pc[i] == PS[i]) begin
          m_pc[i] = 0;
          if (m_cnt[i] == m_lim[i]) begin
            m_exp[i] = 1;
            if (m_per[i]) begin
              m_cnt[i] = 0;
              if (m_wr[i] < 255) m_wr[i]++;
            end else begin
              m_ph[i] = 3;
              m_dn[i] = 1;
            end
          end else m_cnt[i]++;
        end
        if (m_ph[i] == 1 && hold) m_ph[i] = 2;
      end else if (m_ph[i] == 2 && !hold) begin
        m_ph[i] = 1;
      end
      if (rst || clear) m_cap[i] = 0;
      else if (capture) m_cap[i] = old;
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count[%0d]", i),  32'(cnt_o[i]),  32'(m_cnt[i]));
      chk($sformatf("expire[%0d]", i), 32'(exp_o[i]),  32'(m_exp[i]));
      chk($sformatf("done[%0d]", i),   32'(done_o[i]), 32'(m_dn[i]));
      chk($sformatf("busy[%0d]", i),   32'(busy_o[i]), 32'(m_ph[i] == 1 || m_ph[i] == 2));
      chk($sformatf("wraps[%0d]", i),  32'(wr_o[i]),   32'(m_wr[i]));
`ifdef CYCLE_LIMIT_TIMER_CAPTURE_EN
      chk($sformatf("cap[%0d]", i),    32'(cap_o[i]),  32'(m_cap[i]));
`endif
    end
  endtask

  task automatic idle_in();
    rst = 0; start = 0; hold = 0; clear = 0; capture = 0;
  endtask

  task automatic do_start(input int lim, input bit per);
    limit = W'(lim); periodic = per; start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    int first_exp, nexp;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_cnt[i] = 0; m_pc[i] = 0; m_lim[i] = 0; m_wr[i] = 0;
      m_cap[i] = 0; m_per[i] = 0; m_exp[i] = 0; m_dn[i] = 0;
    end
    idle_in(); limit = '0; periodic = 0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("rst_count", 32'(cnt_o[0]), 0);
    chk("rst_busy",  32'(busy_o[0]), 0);
    chk("rst_done",  32'(done_o[0]), 0);

    // One-shot limit 5, prescale 1.
    do_start(5, 0);
    first_exp = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k <= 5) chk("os_count_seq", 32'(cnt_o[0]), 32'(k));
      if (exp_o[0] && first_exp < 0) first_exp = k;
    end
    chk("os_expire_at", 32'(first_exp), 6);
    chk("os_count_hold", 32'(cnt_o[0]), 5);
    chk("os_done", 32'(done_o[0]), 1);
    chk("os_busy", 32'(busy_o[0]), 0);

    // Periodic limit 3 for 20 cycles.
    do_start(3, 1);
    nexp = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("per_count", 32'(cnt_o[0]), 32'(k % 4));
      if (exp_o[0]) begin
        nexp++;
        chk("per_exp_phase", 32'(k % 4), 0);
      end
    end
    chk("per_nexp", 32'(nexp), 5);
    chk("per_wraps", 32'(wr_o[0]), 5);

    // Prescale 4, limit 2, one-shot: plain then with a 3-cycle hold.
    do_start(2, 0);
    first_exp = -1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (exp_o[1] && first_exp < 0) first_exp = k;
    end
    chk("ps4_expire_at", 32'(first_exp), 12);
    do_start(2, 0);
    first_exp = -1;
    for (int k = 1; k <= 18; k++) begin
      hold = (k >= 5 && k <= 7);
      cyc();
      if (exp_o[1] && first_exp < 0) first_exp = k;
    end
    hold = 0;
    chk("ps4_hold_expire_at", 32'(first_exp), 15);

    // start + clear together while running.
    do_start(9, 0);
    cyc(); cyc();
    start = 1; clear = 1;
    cyc();
    start = 0; clear = 0;
    chk("sc_count", 32'(cnt_o[0]), 0);
    chk("sc_busy", 32'(busy_o[0]), 0);
    chk("sc_expire", 32'(exp_o[0]), 0);

    // limit 0 one-shot expires on the first tick.
    do_start(0, 0);
    cyc();
    chk("lim0_expire", 32'(exp_o[0]), 1);
    chk("lim0_done", 32'(done_o[0]), 1);

    // Restart on the very tick that would expire.
    do_start(2, 0);
    cyc(); cyc();
    limit = 8'd4; start = 1;
    cyc();
    start = 0;
    chk("restart_no_expire", 32'(exp_o[0]), 0);
    chk("restart_count", 32'(cnt_o[0]), 0);

    // Reset mid-count.
    do_start(10, 0);
    for (int k = 0; k < 7; k++) cyc();
    chk("pre_rst_count", 32'(cnt_o[0]), 7);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_count", 32'(cnt_o[0]), 0);
    chk("mid_rst_expire", 32'(exp_o[0]), 0);
    chk("mid_rst_busy", 32'(busy_o[0]), 0);

    // Periodic limit 0 saturates wraps.
    do_start(0, 1);
    for (int k = 0; k < 300; k++) cyc();
    chk("wraps_sat", 32'(wr_o[0]), 255);

    // Full-scale limit: count must stop at 255 without overflow.
    do_start(255, 0);
    first_exp = -1;
    for (int k = 1; k <= 258; k++) begin
      cyc();
      if (exp_o[0] && first_exp < 0) first_exp = k;
    end
    chk("max_expire_at", 32'(first_exp), 256);
    chk("max_count", 32'(cnt_o[0]), 255);

`ifdef CYCLE_LIMIT_TIMER_CAPTURE_EN
    do_start(10, 0);
    for (int k = 0; k < 4; k++) cyc();
    capture = 1;
    cyc();
    capture = 0;
    chk("cap_value", 32'(cap_o[0]), 4);
    cyc();
    chk("cap_count_runs", 32'(cnt_o[0]), 6);
    clear = 1;
    cyc();
    clear = 0;
    chk("cap_cleared", 32'(cap_o[0]), 0);
`endif

    // Randomized traffic checked against the model each cycle.
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom % 150) == 0;
      clear   = ($urandom % 60) == 0;
      start   = ($urandom % 25) == 0;
      hold    = ($urandom % 5) == 0;
      capture = ($urandom % 8) == 0;
      periodic = $urandom % 2;
      limit   = (($urandom % 10) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      cyc();
    end
    idle_in();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/cycle_limit_timer.md
CYCLE_LIMIT_TIMER -- requirements
Module: cycle_limit_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and limit width (2..32).
REQ-002 SHALL have parameter PRESCALE, default 1, clk cycles per count tick (1..256).
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: start  in  1  latch limit/mode and begin counting from 0.
REQ-006 SHALL have ports: hold  in  1  level; freeze counting while high.
REQ-007 SHALL have ports: clear  in  1  abort and return to IDLE.
REQ-008 SHALL have ports: limit  in  WIDTH  terminal count, sampled on start only.
REQ-009 SHALL have ports: periodic  in  1  0 = one-shot, 1 = auto-reload; sampled on start only.
REQ-010 SHALL have ports: count  out  WIDTH  current count.
REQ-011 SHALL have ports: expire  out  1  one-cycle pulse on reaching limit.
REQ-012 SHALL have ports: done  out  1  sticky one-shot completion flag.
REQ-013 SHALL have ports: busy  out  1  high in RUN or PAUSE.
REQ-014 SHALL have ports: wraps  out  8  periodic expiries since start, saturating at 255.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-016 Priority per cycle SHALL be clear > start > hold.
REQ-017 clear SHALL go to IDLE next cycle from any state, zero count, done, wraps, prescaler.
REQ-018 start SHALL go to RUN from any state, zero count, prescaler and wraps, clear done, latch limit and periodic.
REQ-019 RUN with hold=1 SHALL go to PAUSE; PAUSE with hold=0 SHALL return to RUN; in PAUSE, count and prescaler are frozen.
REQ-020 Prescaler SHALL generate a tick on every PRESCALE-th clk cycle spent in RUN; the first tick comes PRESCALE cycles after the start cycle.
REQ-021 On a tick with count != latched limit, count SHALL increment by 1.
REQ-022 On a tick with count == latched limit, expire SHALL pulse for exactly one cycle.
REQ-023 In one-shot mode, the expiring tick SHALL move to DONE, hold count at limit, and set done.
REQ-024 In periodic mode, the expiring tick SHALL set count to 0, stay in RUN, and increment wraps, saturating at 255.
REQ-025 limit=0 SHALL expire on the first tick; limit=2^WIDTH-1 SHALL never overflow the count register.
REQ-026 In DONE, the block SHALL ignore hold; only start or clear leave DONE.
REQ-027 start during RUN SHALL restart cleanly; a tick in that same cycle SHALL produce no expire.
REQ-028 busy SHALL equal (state==RUN || state==PAUSE) and be registered.

Reset
REQ-029 rst SHALL have the highest priority of all inputs.
REQ-030 rst SHALL force state=IDLE, count=0, expire=0, done=0, busy=0, wraps=0, prescaler=0, latched limit=0, latched mode=0.
REQ-031 rst mid-count SHALL discard all progress; it SHALL generate no expire.

Configuration
REQ-032 Macro CYCLE_LIMIT_TIMER_CAPTURE_EN SHALL add input capture (1 bit) and output cap_count (WIDTH).
REQ-033 With the macro defined, capture=1 SHALL load count into cap_count next cycle; rst and clear SHALL zero cap_count; cap_count SHALL otherwise hold.
REQ-034 Without the macro, both ports and their logic SHALL be absent.

Structure
REQ-035 Shared package cycle_limit_timer_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3), the mode constants, and the wraps width (8).
REQ-036 Prescaler SHALL be sub-module clt_prescaler, with inputs clk, rst, restart, enable and output tick.
REQ-037 When PRESCALE=1, tick SHALL equal enable.

Verification
REQ-038 WIDTH=8, PRESCALE=1, limit=5, periodic=0, start -> count 1..5, expire pulse exactly 6 cycles after start, done=1, busy=0, count holds 5.
REQ-039 limit=3, periodic=1, run 20 cycles -> expire every 4 cycles, count 0,1,2,3,0..., wraps=5.
REQ-040 PRESCALE=4, limit=2, one-shot -> expire 12 cycles after start; hold high 3 cycles mid-run -> expire delayed to 15 cycles after start.
REQ-041 start and clear in the same cycle during RUN -> state IDLE, count 0, no expire; limit=0 one-shot -> expire 1 cycle after start.
REQ-042 rst asserted at count=7 of limit=10 -> all outputs zero next cycle; periodic limit=0 run 300 cycles -> wraps saturates at 255.
REQ-043 CYCLE_LIMIT_TIMER_CAPTURE_EN defined, capture pulse at count=4 -> cap_count=4 while count continues; clear -> cap_count=0.
